// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for the in-order pipeline. It tracks every instruction past ID
// in a per-stage scoreboard and derives EX forwarding selects, ID stalls and IF/ID flushes from it.
module pipe_hazard_ctrl #(
  parameter int unsigned STAGES   = 3,
  parameter int unsigned LOAD_FWD = 3,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned SELW     = (STAGES > 1) ? $clog2(STAGES) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_valid_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic [4:0]       id_rd_i,
  input  logic             id_regwrite_i,
  input  logic             id_memread_i,
  input  logic             id_branch_i,
  input  logic             branch_taken_i,
  input  logic             ext_stall_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic [SELW-1:0]  fwd_a_o,
  output logic [SELW-1:0]  fwd_b_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef struct packed {
    logic       vld;
    logic [4:0] rd;
    logic       regwrite;
    logic       memread;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use_rs1;
    logic       use_rs2;
  } entry_t;

  // Index 1 is EX, index STAGES is WB.
  entry_t           ent_q [1:STAGES];
  entry_t           id_ent;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             load_use;
  logic             br_haz;
  logic             hz;

  // x0 is hard-wired, so a write to it never produces a dependency.
  function automatic logic match(input entry_t e, input logic [4:0] r);
    return e.vld & e.regwrite & (e.rd == r) & (r != 5'd0);
  endfunction

  always_comb begin
    id_ent          = '0;
    id_ent.vld      = id_valid_i;
    id_ent.rd       = id_rd_i;
    id_ent.regwrite = id_regwrite_i;
    id_ent.memread  = id_memread_i;
    id_ent.rs1      = id_rs1_i;
    id_ent.rs2      = id_rs2_i;
    id_ent.use_rs1  = id_use_rs1_i;
    id_ent.use_rs2  = id_use_rs2_i;
  end

  always_comb begin
    logic dep;
    load_use = 1'b0;
    br_haz   = 1'b0;
    for (int s = 1; s <= int'(STAGES); s++) begin
      dep = (id_use_rs1_i & match(ent_q[s], id_rs1_i)) |
            (id_use_rs2_i & match(ent_q[s], id_rs2_i));
      // A load is unusable until it reaches LOAD_FWD; the consumer would hit EX at s+1.
      if (dep && ent_q[s].memread && ((s + 1) < int'(LOAD_FWD))) load_use = 1'b1;
      // The ID comparator has no bypass, so wait until the producer sits in WB.
      if (dep && id_branch_i && (s < int'(STAGES))) br_haz = 1'b1;
    end
    load_use = load_use & id_valid_i;
    br_haz   = br_haz & id_valid_i;
  end

  assign hz            = load_use | br_haz;
  assign pc_write_o    = ~hz & ~ext_stall_i;
  assign ifid_write_o  = ~hz & ~ext_stall_i;
  assign idex_bubble_o = hz & ~ext_stall_i;
  assign ifid_flush_o  = branch_taken_i & ~hz & ~ext_stall_i;
  assign stall_cnt_o   = stall_cnt_q;

  // Walk from the oldest stage down so the nearest matching producer wins.
  always_comb begin
    fwd_a_o = '0;
    fwd_b_o = '0;
    for (int s = int'(STAGES); s >= 2; s--) begin
      if (!ent_q[s].memread || (s >= int'(LOAD_FWD))) begin
        if (match(ent_q[s], ent_q[1].rs1)) fwd_a_o = SELW'(s - 1);
        if (match(ent_q[s], ent_q[1].rs2)) fwd_b_o = SELW'(s - 1);
      end
    end
    if (!ent_q[1].use_rs1) fwd_a_o = '0;
    if (!ent_q[1].use_rs2) fwd_b_o = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 1; s <= int'(STAGES); s++) ent_q[s] <= '0;
      stall_cnt_q <= '0;
    end else if (!ext_stall_i) begin
      for (int s = int'(STAGES); s >= 2; s--) ent_q[s] <= ent_q[s-1];
      ent_q[1] <= hz ? entry_t'('0) : id_ent;
      if (hz && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: forwarding, load-use, x0, branch stall/flush, freeze, reset.
// A second instance with a 2-bit counter checks saturation.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_memread, id_branch;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        branch_taken, ext_stall;
  logic        pc_write, ifid_write, ifid_flush, idex_bubble;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt;
  logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_bubble;
  logic [1:0]  s_fwd_a, s_fwd_b;
  logic [1:0]  s_stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl u_dut (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2), .id_rd_i(id_rd),
    .id_regwrite_i(id_regwrite), .id_memread_i(id_memread), .id_branch_i(id_branch),
    .branch_taken_i(branch_taken), .ext_stall_i(ext_stall), .pc_write_o(pc_write),
    .ifid_write_o(ifid_write), .ifid_flush_o(ifid_flush), .idex_bubble_o(idex_bubble),
    .fwd_a_o(fwd_a), .fwd_b_o(fwd_b), .stall_cnt_o(stall_cnt)
  );

  pipe_hazard_ctrl #(.CNT_W(2)) u_small (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2), .id_rd_i(id_rd),
    .id_regwrite_i(id_regwrite), .id_memread_i(id_memread), .id_branch_i(id_branch),
    .branch_taken_i(branch_taken), .ext_stall_i(ext_stall), .pc_write_o(s_pc_write),
    .ifid_write_o(s_ifid_write), .ifid_flush_o(s_ifid_flush), .idex_bubble_o(s_idex_bubble),
    .fwd_a_o(s_fwd_a), .fwd_b_o(s_fwd_b), .stall_cnt_o(s_stall_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic [4:0] rd,
                          input logic rw, input logic mr, input logic br);
    id_valid    = v;
    id_rs1      = rs1;
    id_rs2      = rs2;
    id_use_rs1  = u1;
    id_use_rs2  = u2;
    id_rd       = rd;
    id_regwrite = rw;
    id_memread  = mr;
    id_branch   = br;
    #2;
  endtask

  task automatic idle_drain();
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
  endtask

  initial begin
    rst = 1'b1;
    branch_taken = 1'b0;
    ext_stall = 1'b0;
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("rst_pc_write", pc_write, 1);
    check_eq("rst_ifid_write", ifid_write, 1);
    check_eq("rst_flush", ifid_flush, 0);
    check_eq("rst_bubble", idex_bubble, 0);
    check_eq("rst_fwd_a", fwd_a, 0);
    check_eq("rst_fwd_b", fwd_b, 0);
    check_eq("rst_cnt", stall_cnt, 0);
    #10 rst = 1'b0;
    tick();

    // add x5,x1,x2 ; add x6,x5,x1 ; add x7,x2,x5
    drive_id(1, 1, 2, 1, 1, 5, 1, 0, 0);
    check_eq("alu_no_stall", pc_write, 1);
    tick();
    drive_id(1, 5, 1, 1, 1, 6, 1, 0, 0);
    check_eq("alu_dep_no_stall", idex_bubble, 0);
    tick();
    drive_id(1, 2, 5, 1, 1, 7, 1, 0, 0);
    check_eq("fwd_mem_a", fwd_a, 1);
    check_eq("fwd_mem_b", fwd_b, 0);
    tick();
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("fwd_wb_b", fwd_b, 2);
    check_eq("fwd_wb_a", fwd_a, 0);
    tick();
    check_eq("fwd_idle_a", fwd_a, 0);
    idle_drain();

    // lw x5 ; add x8,x5,x3 -> one stall, then WB forward
    drive_id(1, 1, 0, 1, 0, 5, 1, 1, 0);
    tick();
    drive_id(1, 5, 3, 1, 1, 8, 1, 0, 0);
    check_eq("lu_pc_write", pc_write, 0);
    check_eq("lu_ifid_write", ifid_write, 0);
    check_eq("lu_bubble", idex_bubble, 1);
    check_eq("lu_cnt_before", stall_cnt, 0);
    tick();
    check_eq("lu_released", pc_write, 1);
    check_eq("lu_bubble_off", idex_bubble, 0);
    check_eq("lu_cnt_after", stall_cnt, 1);
    check_eq("lu_bubble_fwd", fwd_a, 0);
    tick();
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("lu_fwd_wb", fwd_a, 2);
    idle_drain();

    // lw x0 ; add x0,x0,x0 ; add x10,x0,x0 -> no stall, no forwarding
    drive_id(1, 1, 0, 1, 0, 0, 1, 1, 0);
    tick();
    drive_id(1, 0, 0, 1, 1, 0, 1, 0, 0);
    check_eq("x0_no_stall", idex_bubble, 0);
    tick();
    drive_id(1, 0, 0, 1, 1, 10, 1, 0, 0);
    tick();
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("x0_fwd_a", fwd_a, 0);
    check_eq("x0_fwd_b", fwd_b, 0);
    idle_drain();

    // add x5 ; add x5 ; add x11,x5,(x5 unused) -> nearest wins, unused rs2 forced 0
    drive_id(1, 1, 2, 1, 1, 5, 1, 0, 0);
    tick();
    drive_id(1, 3, 4, 1, 1, 5, 1, 0, 0);
    tick();
    drive_id(1, 5, 5, 1, 0, 11, 1, 0, 0);
    tick();
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("near_fwd_a", fwd_a, 1);
    check_eq("unused_fwd_b", fwd_b, 0);
    idle_drain();

    // add x7 ; beq x7,x1 (taken asserted throughout) -> 2 stall cycles then one flush
    drive_id(1, 1, 2, 1, 1, 7, 1, 0, 0);
    tick();
    branch_taken = 1'b1;
    drive_id(1, 7, 1, 1, 1, 0, 0, 0, 1);
    check_eq("br_stall1_bubble", idex_bubble, 1);
    check_eq("br_stall1_flush", ifid_flush, 0);
    tick();
    check_eq("br_stall2_pc", pc_write, 0);
    check_eq("br_stall2_flush", ifid_flush, 0);
    tick();
    check_eq("br_go_pc", pc_write, 1);
    check_eq("br_go_bubble", idex_bubble, 0);
    check_eq("br_flush", ifid_flush, 1);
    check_eq("br_cnt", stall_cnt, 3);
    check_eq("sat_cnt_3", s_stall_cnt, 3);
    tick();
    branch_taken = 1'b0;
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("br_flush_off", ifid_flush, 0);
    idle_drain();

    // lw x5 ; add x8,x5 with a 3-cycle freeze -> everything holds
    drive_id(1, 1, 0, 1, 0, 5, 1, 1, 0);
    tick();
    ext_stall = 1'b1;
    drive_id(1, 5, 3, 1, 1, 8, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      check_eq("frz_pc_write", pc_write, 0);
      check_eq("frz_bubble", idex_bubble, 0);
      tick();
      check_eq("frz_cnt", stall_cnt, 3);
    end
    ext_stall = 1'b0;
    #1;
    check_eq("frz_hz_kept", idex_bubble, 1);
    tick();
    check_eq("frz_cnt_inc", stall_cnt, 4);
    check_eq("sat_cnt_hold", s_stall_cnt, 3);
    idle_drain();

    // Async reset in the middle of a load-use stall
    drive_id(1, 1, 0, 1, 0, 5, 1, 1, 0);
    tick();
    drive_id(1, 5, 3, 1, 1, 8, 1, 0, 0);
    check_eq("pre_rst_bubble", idex_bubble, 1);
    rst = 1'b1;
    #1;
    check_eq("arst_pc_write", pc_write, 1);
    check_eq("arst_bubble", idex_bubble, 0);
    check_eq("arst_cnt", stall_cnt, 0);
    check_eq("arst_sat_cnt", s_stall_cnt, 0);
    rst = 1'b0;
    idle_drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
